// File: rtl/tiny_alu_pkg.sv
// tiny_alu_pkg: shared opcode/state types for the ALU scheduler.
// Holds op_t, sched_state_t and the opcode legality helpers.
package tiny_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_RESP  = 2'd2
  } sched_state_t;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= 3'(OP_MUL);
  endfunction

  // Legal and not a NO_OP: needs the ALU.
  function automatic logic op_uses_alu(
    input logic [2:0] op
  );
    return op_legal(op) &&
           (op != 3'(OP_NOP));
  endfunction

endpackage

// File: rtl/clk_rst_if.sv
// clk_rst_if: shared clock / reset bundle.
// clk, rst (asynchronous, active-high).
interface clk_rst_if;
  logic clk;
  logic rst;

  modport src  (output clk, rst);
  modport sink (input  clk, rst);
endinterface

// File: rtl/tiny_alu_sched_if.sv
// tiny_alu_sched_if: requester and ALU signals of the scheduler.
// master = requesters + ALU side, slave = scheduler.
interface tiny_alu_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b_i;
  logic [NUM_REQ-1:0][2:0]        req_op_i;
  logic [NUM_REQ-1:0]             rsp_valid_o;
  logic [2*DATA_W-1:0]            rsp_result_o;
  logic                           rsp_err_o;
  logic                           alu_start_o;
  logic [2:0]                     alu_op_o;
  logic [DATA_W-1:0]              alu_a_o;
  logic [DATA_W-1:0]              alu_b_o;
  logic                           alu_done_i;
  logic [2*DATA_W-1:0]            alu_result_i;

  modport slave (
    input  req_valid_i, req_a_i,
           req_b_i, req_op_i,
           alu_done_i, alu_result_i,
    output req_ready_o, rsp_valid_o,
           rsp_result_o, rsp_err_o,
           alu_start_o, alu_op_o,
           alu_a_o, alu_b_o
  );

  modport master (
    output req_valid_i, req_a_i,
           req_b_i, req_op_i,
           alu_done_i, alu_result_i,
    input  req_ready_o, rsp_valid_o,
           rsp_result_o, rsp_err_o,
           alu_start_o, alu_op_o,
           alu_a_o, alu_b_o
  );
endinterface

// File: rtl/tiny_alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// i_req, i_last -> o_gnt (one-hot), o_idx, o_any.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [LW-1:0]      o_idx,
  output logic               o_any
);

  int w_j;

  // Walk from farthest (i_last itself) to
  // nearest (i_last+1); nearest hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_j = (int'(i_last) + k) % NUM_REQ;
      if (i_req[LW'(w_j)]) begin
        o_gnt = NUM_REQ'(1) << w_j;
        o_idx = LW'(w_j);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tiny_alu_sched.sv
// tiny_alu_sched: round-robin scheduler sharing one tiny_alu.
// Ports: i_clk_rst (clk/rst), io_bus (requesters + ALU).
module tiny_alu_sched
  import tiny_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  clk_rst_if.sink         i_clk_rst,
  tiny_alu_sched_if.slave io_bus
);

  localparam int LW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int RW = 2 * DATA_W;

  localparam logic [1:0] S_IDLE  = SCHED_IDLE;
  localparam logic [1:0] S_ISSUE = SCHED_ISSUE;
  localparam logic [1:0] S_RESP  = SCHED_RESP;

  logic w_clk;
  logic w_rst;

  assign w_clk = i_clk_rst.clk;
  assign w_rst = i_clk_rst.rst;

  logic [1:0]        r_state;
  logic [LW-1:0]     r_last;
  logic [LW-1:0]     r_gnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [2:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_result;
  logic              r_err;

  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [LW-1:0]      w_gnt_idx;
  logic               w_any;
  logic [2:0]         w_op;
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic               w_idle;
  logic               w_issue;
  logic               w_resp;
  logic               w_tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LW      (LW)
  ) u_arb (
    .i_req  (io_bus.req_valid_i),
    .i_last (r_last),
    .o_gnt  (w_gnt_oh),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  assign w_op = io_bus.req_op_i[w_gnt_idx];
  assign w_a  = io_bus.req_a_i[w_gnt_idx];
  assign w_b  = io_bus.req_b_i[w_gnt_idx];

  assign w_idle  = (r_state == S_IDLE);
  assign w_issue = (r_state == S_ISSUE);
  assign w_resp  = (r_state == S_RESP);

  // Last permitted ISSUE cycle without done.
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state  <= S_IDLE;
      r_last   <= LW'(NUM_REQ - 1);
      r_gnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_gnt_idx;
            r_a      <= w_a;
            r_b      <= w_b;
            r_op     <= w_op;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= ~op_legal(w_op);
            // NO_OP / illegal bypass the ALU.
            r_state  <= op_uses_alu(w_op)
                        ? S_ISSUE : S_RESP;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          unique case (1'b1)
            io_bus.alu_done_i: begin
              r_result <= io_bus.alu_result_i;
              r_err    <= 1'b0;
              r_state  <= S_RESP;
            end
            w_tmo: begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= S_RESP;
            end
            default: ;
          endcase
        end
        S_RESP: begin
          r_last  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.req_ready_o =
    w_idle ? w_gnt_oh : '0;

  assign io_bus.alu_start_o = w_issue;
  assign io_bus.alu_op_o =
    w_issue ? r_op : '0;
  assign io_bus.alu_a_o =
    w_issue ? r_a : '0;
  assign io_bus.alu_b_o =
    w_issue ? r_b : '0;

  assign io_bus.rsp_valid_o =
    w_resp ? (NUM_REQ'(1) << r_gnt) : '0;
  assign io_bus.rsp_result_o =
    w_resp ? r_result : '0;
  assign io_bus.rsp_err_o =
    w_resp & r_err;

endmodule

// File: tb/tb_tiny_alu_sched.sv
// tb_tiny_alu_sched: directed vectors for tiny_alu_sched.
// Bench drives requesters and a latency-programmable ALU model.
module tb_tiny_alu_sched;

  clk_rst_if cr ();
  tiny_alu_sched_if #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) bus ();

  tiny_alu_sched #(
    .NUM_REQ (4),
    .DATA_W  (8),
    .TIMEOUT (15)
  ) dut (
    .i_clk_rst (cr),
    .io_bus    (bus)
  );

  initial cr.clk = 1'b0;
  always #5 cr.clk = ~cr.clk;

  // ALU model: done in the m_lat-th cycle of start
  // (m_lat == 0 means never), plus a forced spurious done.
  int          m_lat;
  logic        m_spur;
  int          m_cnt;
  logic [15:0] m_res;

  always @(posedge cr.clk or posedge cr.rst) begin
    if (cr.rst)
      m_cnt <= 0;
    else if (!bus.alu_start_o)
      m_cnt <= 0;
    else
      m_cnt <= m_cnt + 1;
  end

  assign bus.alu_done_i = m_spur ||
    (bus.alu_start_o && m_lat != 0 &&
     m_cnt == m_lat - 1);

  always_comb begin
    m_res = '0;
    case (bus.alu_op_o)
      3'd1: m_res = {8'h0, bus.alu_a_o} + {8'h0, bus.alu_b_o};
      3'd2: m_res = {8'h0, bus.alu_a_o & bus.alu_b_o};
      3'd3: m_res = {8'h0, bus.alu_a_o ^ bus.alu_b_o};
      3'd4: m_res = 16'(bus.alu_a_o) * 16'(bus.alu_b_o);
      default: m_res = '0;
    endcase
  end

  assign bus.alu_result_i =
    bus.alu_done_i ? m_res : '0;

  int n_chk;
  int n_pass;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  task automatic step();
    @(posedge cr.clk);
    #2;
  endtask

  typedef struct {
    int         idx;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    logic [15:0] res;
    logic       err;
    int         rlat;
    int         starts;
  } vec_t;

  vec_t vt[9];

  task automatic run_vec(input vec_t v);
    int   k;
    int   starts;
    logic seen;
    m_lat = v.lat;
    bus.req_valid_i = '0;
    bus.req_valid_i[v.idx] = 1'b1;
    bus.req_op_i[v.idx] = v.op;
    bus.req_a_i[v.idx] = v.a;
    bus.req_b_i[v.idx] = v.b;
    #1;
    chk("ready", 32'(bus.req_ready_o), 32'(1) << v.idx);
    k = 0;
    starts = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      step();
      k++;
      bus.req_valid_i = '0;
      #1;
      if (bus.alu_start_o) begin
        starts++;
        chk("alu_op", 32'(bus.alu_op_o), 32'(v.op));
        chk("alu_a", 32'(bus.alu_a_o), 32'(v.a));
        chk("alu_b", 32'(bus.alu_b_o), 32'(v.b));
      end
      if (bus.rsp_valid_o != '0) begin
        seen = 1'b1;
        chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(1) << v.idx);
        chk("rsp_result", 32'(bus.rsp_result_o), 32'(v.res));
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(v.err));
        chk("rsp_latency", k, v.rlat);
      end
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("start_cycles", starts, v.starts);
    step();
    #1;
    chk("start_gap", 32'(bus.alu_start_o), 32'd0);
    chk("rsp_one_cycle", 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    int exp_ord[5];
    int g;
    int r;
    n_chk = 0;
    n_pass = 0;
    m_lat = 1;
    m_spur = 1'b0;
    bus.req_valid_i = '0;
    bus.req_a_i = '0;
    bus.req_b_i = '0;
    bus.req_op_i = '0;
    cr.rst = 1'b1;

    //     idx op    a      b      lat res       err rlat st
    vt[0] = '{0, 3'd1, 8'hFF, 8'h01, 1, 16'h0100, 0, 2,  1};
    vt[1] = '{2, 3'd4, 8'd200, 8'd3, 3, 16'd600,  0, 4,  3};
    vt[2] = '{1, 3'd0, 8'h05, 8'h06, 1, 16'h0000, 0, 1,  0};
    vt[3] = '{3, 3'd7, 8'h12, 8'h34, 1, 16'h0000, 1, 1,  0};
    vt[4] = '{1, 3'd2, 8'hF0, 8'h3C, 2, 16'h0030, 0, 3,  2};
    vt[5] = '{3, 3'd3, 8'hAA, 8'h0F, 1, 16'h00A5, 0, 2,  1};
    vt[6] = '{0, 3'd5, 8'h01, 8'h02, 1, 16'h0000, 1, 1,  0};
    vt[7] = '{2, 3'd4, 8'hFF, 8'hFF, 1, 16'hFE01, 0, 2,  1};
    vt[8] = '{1, 3'd1, 8'h80, 8'h80, 0, 16'h0000, 1, 16, 15};

    step();
    step();
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_result", 32'(bus.rsp_result_o), 32'd0);
    chk("rst_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst_start", 32'(bus.alu_start_o), 32'd0);
    chk("rst_op", 32'(bus.alu_op_o), 32'd0);
    chk("rst_a", 32'(bus.alu_a_o), 32'd0);
    chk("rst_b", 32'(bus.alu_b_o), 32'd0);
    cr.rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Spurious done while idle must not respond.
    m_spur = 1'b1;
    #1;
    chk("spur_rsp0", 32'(bus.rsp_valid_o), 32'd0);
    step();
    m_spur = 1'b0;
    #1;
    chk("spur_rsp1", 32'(bus.rsp_valid_o), 32'd0);
    chk("spur_start", 32'(bus.alu_start_o), 32'd0);

    // Reset in the middle of an ALU operation.
    m_lat = 0;
    bus.req_valid_i = 4'b0100;
    bus.req_op_i[2] = 3'd1;
    bus.req_a_i[2] = 8'h11;
    bus.req_b_i[2] = 8'h22;
    step();
    bus.req_valid_i = '0;
    step();
    step();
    #1;
    chk("mid_start", 32'(bus.alu_start_o), 32'd1);
    cr.rst = 1'b1;
    #1;
    chk("mrst_start", 32'(bus.alu_start_o), 32'd0);
    chk("mrst_op", 32'(bus.alu_op_o), 32'd0);
    chk("mrst_a", 32'(bus.alu_a_o), 32'd0);
    chk("mrst_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("mrst_ready", 32'(bus.req_ready_o), 32'd0);
    step();
    cr.rst = 1'b0;

    // All four valid: order 0,1,2,3,0 and fresh ADDs complete.
    m_lat = 1;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      bus.req_op_i[i] = 3'd1;
      bus.req_a_i[i] = 8'(i + 1);
      bus.req_b_i[i] = 8'h10;
    end
    bus.req_valid_i = 4'hF;
    g = 0;
    r = 0;
    #1;
    for (int c = 0; c < 40 && r < 5; c++) begin
      if (bus.req_ready_o != '0 && g < 5) begin
        chk("grant_order", 32'(bus.req_ready_o),
            32'(1) << exp_ord[g]);
        g++;
      end
      if (bus.rsp_valid_o != '0 && r < 5) begin
        chk("fair_rsp", 32'(bus.rsp_valid_o),
            32'(1) << exp_ord[r]);
        chk("fair_result", 32'(bus.rsp_result_o),
            32'(exp_ord[r] + 1 + 16));
        chk("fair_err", 32'(bus.rsp_err_o), 32'd0);
        r++;
      end
      step();
      if (g == 5) bus.req_valid_i = '0;
      #1;
    end
    chk("fair_grants", g, 5);
    chk("fair_rsps", r, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
